// File: rtl/spi_master.sv
// SPI initiator: single-byte read/write to an SPI memory slave (7b addr, R/W, 8b data, MSB first).
// Latency: done in cycle E0 + 2*CLK_DIV*(N+1) + 1 after accept at E0 (N = 16 write, 17 read).
// Backpressure: start is only sampled in IDLE; requests while busy/done are dropped, never queued.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   start, rw, addr,    request handshake; rw/addr/wdata latched when start is accepted
//   wdata
//   busy, done, rdata   status: busy through DONE, one-cycle done pulse, last read byte
//   sclk_pin, cs_pin,   SPI pins (sclk idles low, cs active low)
//   mosi_pin, miso_pin
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk_pin,
  output logic       cs_pin,
  output logic       mosi_pin,
  input  logic       miso_pin
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;   // sclk rising edges issued so far
  logic [15:0]       shift_q, shift_d;
  logic              rd_q, rd_d;
  logic [7:0]        cap_q, cap_d;
  logic              sclk_q, sclk_d;
  logic              cs_q, cs_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        rdata_q, rdata_d;

  logic              tick;
  logic [4:0]        n_bits;

  assign tick   = (div_q == DIV_LAST);
  // A read carries one extra sclk cycle: the turnaround between command and data.
  assign n_bits = rd_q ? 5'd17 : 5'd16;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rd_d      = rd_q;
    cap_d     = cap_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = done_q;
    rdata_d   = rdata_q;

    // The half-period divider only runs while the bus is owned and clocking.
    if (state_q == S_SETUP || state_q == S_SHIFT || state_q == S_HOLD) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
    end else begin
      div_d = '0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SETUP;
          rd_d      = rw;
          shift_d   = {addr, rw, wdata};
          bit_cnt_d = 5'd0;
          cap_d     = 8'h00;
          cs_d      = 1'b0;
          sclk_d    = 1'b0;
          mosi_d    = addr[6];
          busy_d    = 1'b1;
        end
      end

      S_SETUP: begin
        if (tick) begin
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            // Rising edge: slave samples mosi, master samples miso now.
            // Only the 8 data edges after the turnaround are captured, so
            // miso is never looked at during command or turnaround cycles.
            sclk_d    = 1'b1;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (rd_q && (bit_cnt_q >= 5'd9)) begin
              cap_d = {cap_q[6:0], miso_pin};
            end
          end else begin
            // Falling edge: advance mosi to the next bit. A read drives 0
            // once the 8 command bits are out.
            sclk_d  = 1'b0;
            shift_d = {shift_q[14:0], 1'b0};
            mosi_d  = (rd_q && (bit_cnt_q >= 5'd8)) ? 1'b0 : shift_q[14];
            if (bit_cnt_q == n_bits) begin
              state_d = S_HOLD;
            end
          end
        end
      end

      S_HOLD: begin
        if (tick) begin
          state_d = S_DONE;
          cs_d    = 1'b1;
          done_d  = 1'b1;
          if (rd_q) begin
            rdata_d = cap_q;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      bit_cnt_q <= 5'd0;
      shift_q   <= 16'h0000;
      rd_q      <= 1'b0;
      cap_q     <= 8'h00;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rd_q      <= rd_d;
      cap_q     <= cap_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign sclk_pin = sclk_q;
  assign cs_pin   = cs_q;
  assign mosi_pin = mosi_q;

endmodule
